// File: rtl/sevensegments_pkg.sv
// Shared types and constants for the seven-segment write scheduler.
package sevensegments_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StGap
  } state_e;

  localparam int unsigned SEG_A      = 0;
  localparam int unsigned SEG_B      = 1;
  localparam int unsigned SEG_C      = 2;
  localparam int unsigned SEG_D      = 3;
  localparam int unsigned SEG_E      = 4;
  localparam int unsigned SEG_F      = 5;
  localparam int unsigned SEG_G      = 6;
  localparam int unsigned SEG_DP_BIT = 7;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_DP    = 8'h01 << SEG_DP_BIT;

  // Entry 0 is the rightmost element: index by hex value.
  localparam logic [15:0][7:0] SEG_HEX = {
    8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

endpackage

// File: rtl/sevensegments_hex_enc.sv
// Combinational hex digit to active-high segment byte encoder.
module sevensegments_hex_enc
  import sevensegments_pkg::*;
(
  input  logic [3:0] value,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_HEX[value] | (dp ? SEG_DP : SEG_BLANK);
    if (blank) seg = SEG_BLANK;
  end

endmodule

// File: rtl/sevensegments_sched.sv
// Round-robin write scheduler feeding single-digit updates and clears to the display port.
module sevensegments_sched
  import sevensegments_pkg::*;
#(
  parameter int unsigned GAP = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_digit,
  input  logic [3:0]  req0_value,
  input  logic        req0_dp,
  input  logic        req0_blank,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_digit,
  input  logic [3:0]  req1_value,
  input  logic        req1_dp,
  input  logic        req1_blank,
  input  logic        clear,
  output logic        start_port,
  output logic [63:0] val,
  output logic [63:0] mask,
  output logic        busy
);

  localparam int unsigned CntW = (GAP > 1) ? $clog2(GAP) : 1;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rr_q, rr_d;
  logic            clr_pend_q, clr_pend_d;
  logic [63:0]     val_q, val_d, mask_q, mask_d;

  logic       idle, clr_now, any_valid, sel1, xfer;
  logic [2:0] g_digit;
  logic [3:0] g_value;
  logic       g_dp, g_blank;
  logic [7:0] g_seg;

  assign idle      = (state_q == StIdle);
  assign clr_now   = clear | clr_pend_q;
  assign any_valid = req0_valid | req1_valid;
  // rr names the preferred requester; the other wins only when it is idle.
  assign sel1      = rr_q ? req1_valid : ~req0_valid;

  assign req0_ready = ~reset & idle & ~clr_now & any_valid & ~sel1;
  assign req1_ready = ~reset & idle & ~clr_now & any_valid & sel1;
  assign xfer       = req0_ready | req1_ready;

  assign g_digit = sel1 ? req1_digit : req0_digit;
  assign g_value = sel1 ? req1_value : req0_value;
  assign g_dp    = sel1 ? req1_dp    : req0_dp;
  assign g_blank = sel1 ? req1_blank : req0_blank;

  sevensegments_hex_enc u_hex_enc (
    .value (g_value),
    .dp    (g_dp),
    .blank (g_blank),
    .seg   (g_seg)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
    clr_pend_d = clr_pend_q;
    val_d      = val_q;
    mask_d     = mask_q;
    unique case (state_q)
      StIdle: begin
        if (clr_now) begin
          val_d      = '0;
          mask_d     = '1;
          clr_pend_d = 1'b0;
          state_d    = StIssue;
        end else if (xfer) begin
          val_d   = 64'(g_seg) << {g_digit, 3'b000};
          mask_d  = 64'hFF << {g_digit, 3'b000};
          rr_d    = ~sel1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (clear) clr_pend_d = 1'b1;
        if (GAP > 0) begin
          cnt_d   = CntW'(GAP - 1);
          state_d = StGap;
        end else begin
          state_d = StIdle;
        end
      end
      StGap: begin
        if (clear) clr_pend_d = 1'b1;
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rr_q       <= 1'b0;
      clr_pend_q <= 1'b0;
      val_q      <= '0;
      mask_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      clr_pend_q <= clr_pend_d;
      val_q      <= val_d;
      mask_q     <= mask_d;
    end
  end

  // Decoding from state keeps the strobe asynchronous to reset.
  assign start_port = (state_q == StIssue);
  assign val        = start_port ? val_q  : '0;
  assign mask       = start_port ? mask_q : '0;
  assign busy       = ~idle | clr_pend_q;

endmodule

// File: tb/tb_sevensegments_sched.sv
// Scoreboard bench for sevensegments_sched (GAP=4 main instance, GAP=0 side instance).
module tb_sevensegments_sched;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        req0_valid = 0, req0_dp = 0, req0_blank = 0;
  logic [2:0]  req0_digit = 0;
  logic [3:0]  req0_value = 0;
  logic        req1_valid = 0, req1_dp = 0, req1_blank = 0;
  logic [2:0]  req1_digit = 0;
  logic [3:0]  req1_value = 0;
  logic        clear = 0;
  logic        req0_ready, req1_ready, start_port, busy;
  logic [63:0] val, mask;

  logic        g0_valid = 0;
  logic        g0_ready0, g0_ready1, g0_start, g0_busy;
  logic [63:0] g0_val, g0_mask;
  logic        zero1 = 1'b0;
  logic [2:0]  zero3 = 3'd0;
  logic [3:0]  zero4 = 4'd0;

  sevensegments_sched #(.GAP(4)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_digit(req0_digit),
    .req0_value(req0_value), .req0_dp(req0_dp), .req0_blank(req0_blank),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_digit(req1_digit),
    .req1_value(req1_value), .req1_dp(req1_dp), .req1_blank(req1_blank),
    .clear(clear), .start_port(start_port), .val(val), .mask(mask), .busy(busy)
  );

  sevensegments_sched #(.GAP(0)) dut_g0 (
    .clock(clock), .reset(reset),
    .req0_valid(g0_valid), .req0_ready(g0_ready0), .req0_digit(3'd7),
    .req0_value(4'hF), .req0_dp(1'b0), .req0_blank(1'b0),
    .req1_valid(zero1), .req1_ready(g0_ready1), .req1_digit(zero3),
    .req1_value(zero4), .req1_dp(zero1), .req1_blank(zero1),
    .clear(zero1), .start_port(g0_start), .val(g0_val), .mask(g0_mask), .busy(g0_busy)
  );

  typedef struct packed {
    logic [63:0] v;
    logic [63:0] m;
  } wr_t;

  localparam logic [7:0] HEX [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };
  localparam wr_t CLR_WR = '{v: 64'h0, m: {64{1'b1}}};

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  wr_t  exp_q[$];
  int   grants[$];
  int   strobes[$];
  int   g0_strobes[$];
  wr_t  popped;

  function automatic wr_t model(input logic [2:0] d, input logic [3:0] v, input logic dp,
                                input logic bl);
    logic [7:0] b;
    b = bl ? 8'h00 : (HEX[v] | (dp ? 8'h80 : 8'h00));
    model.v = 64'(b) << (8 * d);
    model.m = 64'hFF << (8 * d);
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // Push on handshake, pop on strobe.
  always @(negedge clock) begin
    if (!reset) begin
      if (req0_valid && req0_ready) begin
        exp_q.push_back(model(req0_digit, req0_value, req0_dp, req0_blank));
        grants.push_back(0);
      end
      if (req1_valid && req1_ready) begin
        exp_q.push_back(model(req1_digit, req1_value, req1_dp, req1_blank));
        grants.push_back(1);
      end
      if (start_port) begin
        strobes.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL strobe_unexpected: val=%h mask=%h, required no strobe", val, mask);
        end else begin
          popped = exp_q.pop_front();
          if ({val, mask} !== {popped.v, popped.m}) begin
            errors++;
            $display("FAIL strobe_data: val=%h mask=%h, required val=%h mask=%h",
                     val, mask, popped.v, popped.m);
          end
        end
      end
      if (g0_start) begin
        g0_strobes.push_back(cyc);
        checks++;
        if ({g0_val, g0_mask} !== {64'h7100_0000_0000_0000, 64'hFF00_0000_0000_0000}) begin
          errors++;
          $display("FAIL gap0_data: val=%h mask=%h", g0_val, g0_mask);
        end
      end
    end
  end

  task automatic apply_reset();
    reset = 1'b1;
    clear = 0; req0_valid = 0; req1_valid = 0; g0_valid = 0;
    repeat (2) @(posedge clock);
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic wait_grant(input int which);
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if ((which == 0) ? req0_ready : req1_ready) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL grant_timeout: req%0d got no ready within 50 cycles", which);
    end
    @(posedge clock); #1;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (!busy && !start_port) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL idle_timeout: busy=%b", busy); end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL writes_missing: %0d queued, required 0", exp_q.size());
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0_valid = 1; req1_valid = 1;
    #3;
    checks++;
    if ({start_port, val, mask, req0_ready, req1_ready, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: sp=%b val=%h mask=%h rdy=%b%b busy=%b, required all 0",
               start_port, val, mask, req0_ready, req1_ready, busy);
    end
    apply_reset();
    @(negedge clock);
    checks++;
    if ({start_port, busy, req0_ready, req1_ready} !== 4'b0) begin
      errors++;
      $display("FAIL post_reset_idle: sp=%b busy=%b rdy=%b%b, required 0", start_port, busy,
               req0_ready, req1_ready);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_single();
    apply_reset();
    req0_digit = 2; req0_value = 4'hA; req0_dp = 0; req0_blank = 0; req0_valid = 1;
    @(negedge clock);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL single_ready: ready0/1=%b%b, required 10", req0_ready, req1_ready);
    end
    @(posedge clock); #1;
    req0_valid = 0;
    @(negedge clock);
    checks++;
    if ({start_port, val, mask} !== {1'b1, 64'h0000_0000_0077_0000, 64'h0000_0000_00FF_0000}) begin
      errors++;
      $display("FAIL single_strobe: sp=%b val=%h mask=%h, required 1/770000/ff0000",
               start_port, val, mask);
    end
    @(posedge clock); #1;
    wait_idle();
  endtask

  task automatic test_alternate();
    int gb, sb;
    int exp_g[4] = '{0, 1, 0, 1};
    apply_reset();
    gb = grants.size(); sb = strobes.size();
    req0_digit = 3; req0_value = 4'h5; req0_dp = 0; req0_blank = 0;
    req1_digit = 0; req1_value = 4'h8; req1_dp = 1; req1_blank = 0;
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 60 && grants.size() < gb + 4; i++) @(posedge clock);
    #1;
    req0_valid = 0; req1_valid = 0;
    wait_idle();
    checks++;
    if (grants.size() != gb + 4 || strobes.size() != sb + 4) begin
      errors++;
      $display("FAIL alt_count: grants=%0d strobes=%0d, required 4/4",
               grants.size() - gb, strobes.size() - sb);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (grants[gb+i] != exp_g[i]) begin
          errors++;
          $display("FAIL alt_order[%0d]: req%0d, required req%0d", i, grants[gb+i], exp_g[i]);
        end
      end
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (strobes[sb+i] - strobes[sb+i-1] != 6) begin
          errors++;
          $display("FAIL alt_spacing[%0d]: %0d cycles, required 6", i,
                   strobes[sb+i] - strobes[sb+i-1]);
        end
      end
    end
  endtask

  task automatic test_clear_in_gap();
    apply_reset();
    req0_digit = 1; req0_value = 4'h3; req0_dp = 0; req0_blank = 0; req0_valid = 1;
    wait_grant(0);
    req0_valid = 0;
    req1_digit = 4; req1_value = 4'h7; req1_dp = 0; req1_blank = 0; req1_valid = 1;
    @(posedge clock); #1;
    clear = 1;
    exp_q.push_back(CLR_WR);
    @(posedge clock); #1;
    clear = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (req1_ready) break;
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL clear_gap_busy: busy=%b at cycle %0d, required 1", busy, cyc);
      end
    end
    @(posedge clock); #1;
    req1_valid = 0;
    wait_idle();
  endtask

  task automatic test_clear_and_req();
    apply_reset();
    req0_digit = 6; req0_value = 4'hC; req0_dp = 1; req0_blank = 0; req0_valid = 1;
    clear = 1;
    exp_q.push_back(CLR_WR);
    @(negedge clock);
    checks++;
    if (req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_beats_req: ready0=%b, required 0", req0_ready);
    end
    @(posedge clock); #1;
    clear = 0;
    wait_grant(0);
    req0_valid = 0;
    wait_idle();
  endtask

  task automatic test_double_clear();
    int sb;
    apply_reset();
    sb = strobes.size();
    req0_digit = 5; req0_value = 4'h0; req0_dp = 0; req0_blank = 1; req0_valid = 1;
    wait_grant(0);
    req0_valid = 0;
    @(posedge clock); #1;
    clear = 1;
    exp_q.push_back(CLR_WR);
    @(posedge clock); #1;
    clear = 0;
    @(posedge clock); #1;
    clear = 1;
    @(posedge clock); #1;
    clear = 0;
    wait_idle();
    repeat (8) @(posedge clock);
    #1;
    checks++;
    if (strobes.size() - sb != 2) begin
      errors++;
      $display("FAIL double_clear: %0d strobes, required 2", strobes.size() - sb);
    end
  endtask

  task automatic test_reset_issue();
    int sb;
    apply_reset();
    req0_digit = 0; req0_value = 4'h1; req0_dp = 0; req0_blank = 0; req0_valid = 1;
    wait_grant(0);
    req0_valid = 0;
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({start_port, val, mask, req0_ready, req1_ready, busy} !== '0) begin
      errors++;
      $display("FAIL reset_in_issue: sp=%b val=%h mask=%h busy=%b, required all 0",
               start_port, val, mask, busy);
    end
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
    sb = strobes.size();
    repeat (10) @(posedge clock);
    #1;
    checks++;
    if (strobes.size() != sb || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_strobe: %0d strobes busy=%b, required 0/0",
               strobes.size() - sb, busy);
    end
  endtask

  task automatic test_gap0();
    int n;
    apply_reset();
    n = g0_strobes.size();
    g0_valid = 1;
    repeat (12) @(posedge clock);
    #1;
    g0_valid = 0;
    repeat (4) @(posedge clock);
    #1;
    checks++;
    if (g0_strobes.size() - n < 4) begin
      errors++;
      $display("FAIL gap0_count: %0d strobes, required at least 4", g0_strobes.size() - n);
    end else begin
      for (int i = n + 1; i < g0_strobes.size(); i++) begin
        checks++;
        if (g0_strobes[i] - g0_strobes[i-1] != 2) begin
          errors++;
          $display("FAIL gap0_spacing: %0d cycles, required 2", g0_strobes[i] - g0_strobes[i-1]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_clear_in_gap();
    test_clear_and_req();
    test_double_clear();
    test_reset_issue();
    test_gap0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sevensegments_sched.md
# sevensegments_sched

Write scheduler for the pong seven-segment display controller. It takes single-digit update requests from two independent producers (e.g. score logic and game-state logic) plus a global clear, and arbitrates them round-robin. Each granted request is encoded into segment patterns and issued to the display controller's `start_port`/`val`/`mask` write port as a one-cycle write pulse. Writes are spaced by a configurable minimum gap.

## Interface
- `GAP`, default 4: idle cycles enforced after each write pulse before the next grant (0 allowed).
- `clock  in  1`: single clock, all state on rising edge.
- `reset  in  1`: asynchronous, active-high; forces every register to its reset value.
- `reqN_valid  in  1` (N=0,1): request pending.
- `reqN_ready  out  1`: grant; transfer occurs on `valid && ready`.
- `reqN_digit  in  3`: target digit 0..7 (byte lane `digit*8+:8`).
- `reqN_value  in  4`: hex value 0..F.
- `reqN_dp  in  1`: decimal point on.
- `reqN_blank  in  1`: blank the digit; overrides value and dp.
- `clear  in  1`: one-cycle pulse requesting that all eight digits be blanked.
- `start_port  out  1`: write strobe to the display controller.
- `val  out  64`: active-high segment pattern; 1 = segment lit.
- `mask  out  64`: byte-lane write enable.
- `busy  out  1`: high whenever the FSM is not in IDLE or a clear is pending.

## Operation
- Segment byte: bit0..6 = a..g, bit7 = dp. Hex table: 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71. dp ORs in 0x80. Blank → 00.
- FSM states are IDLE, ISSUE, and GAP.
- **IDLE**
  - If `clear_pending` is set, or `clear` is high this cycle: register val=0 and mask=all-ones, clear `clear_pending`, and go to ISSUE. No `ready` is asserted that cycle.
  - Otherwise, if any valid is high: assert `ready` combinationally to exactly one requester. The requester selected by the `rr` pointer wins if valid; otherwise the other requester wins.
  - On transfer: register the encoded byte into lane `digit` of `val`, 0xFF into the same lane of `mask`, and zeros elsewhere. Set `rr` to the non-granted requester and go to ISSUE.
- **ISSUE**
  - `start_port` = 1 for exactly this cycle, with `val`/`mask` holding the registered words.
  - Next state is GAP if `GAP > 0`, else IDLE. The gap counter loads `GAP-1`.
- **GAP**: decrement the counter; at 0, go to IDLE.
- Outside ISSUE, `val` and `mask` are driven to 0.
- `clear` arriving in ISSUE or GAP sets `clear_pending`. Repeated clears coalesce into a single write.
- `reqN_ready` is never high outside IDLE. Requesters must hold their payload stable while valid and not ready.

## Timing
- Reset values: `start_port`=0, `val`=0, `mask`=0, `reqN_ready`=0, `busy`=0, `rr`=0, `clear_pending`=0, state=IDLE.
- Latency: transfer at cycle T gives `start_port` at T+1. The earliest next transfer is T+2+GAP.
- Throughput is one write per `GAP+2` cycles.
- Simultaneous valid on both requesters: grant follows `rr` and alternates strictly while both stay valid.
- Simultaneous `clear` and valid in IDLE: clear wins. The request is served at the following IDLE.
- Reset asserted mid-ISSUE: `start_port` drops asynchronously and no partial write completes. Any pending clear is lost.
- `digit` values 0..7 all map to valid lanes, so there is no out-of-range case.

## Structure
- Package `sevensegments_pkg` holds:
  - the state enum;
  - segment bit-position constants;
  - the 16-entry hex→segment constant table;
  - the `SEG_BLANK`/`SEG_DP` constants.
- Sub-module `sevensegments_hex_enc` is a combinational encoder: value, dp, blank → 8-bit byte. Instantiate it once, after the grant mux.
- Arbiter, FSM, gap counter and output registers live in the top module.

## Test plan
- Reset, then req0 with digit=2, value=A, dp=0 → `ready0` the same cycle; next cycle `start_port`=1, `val`=0x0000_0000_0077_0000, `mask`=0x0000_0000_00FF_0000.
- req0 and req1 both held valid, GAP=4 → grants alternate 0,1,0,1. Strobes are exactly 6 cycles apart; req1 digit=0, value=8, dp=1 → `val[7:0]`=FF.
- `clear` pulse during GAP → `busy` stays high. At the next IDLE, a strobe is issued with `val`=0 and `mask`=all-ones before the pending req1 is granted.
- `clear` and req0 valid in the same IDLE cycle → `ready0`=0, the clear strobe is issued first, and req0 is granted afterwards.
- Two `clear` pulses within one GAP window → exactly one clear strobe.
- `reset` asserted in the ISSUE cycle → `start_port`=0 immediately, all outputs return to reset values, and no strobe follows. GAP=0 variant: strobes are 2 cycles apart.
